// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MIPS MEM stage and its MEM/WB register.
package mem_access_stage_pkg;

  localparam int SIZE     = 32;
  localparam int REG_ADDR = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                valid;
    logic                MemToReg;
    logic                RegWrite;
    logic [SIZE-1:0]     readData;
    logic [SIZE-1:0]     ALUResult;
    logic [REG_ADDR-1:0] writeReg;
  } memWb_t;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: valid follows its input every cycle, payload loads on en.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  memWb_t d,
  output memWb_t q
);

  // Payload holds across bubbles so the write-back side sees stable fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q.valid <= d.valid;
      if (en) begin
        q.MemToReg  <= d.MemToReg;
        q.RegWrite  <= d.RegWrite;
        q.readData  <= d.readData;
        q.ALUResult <= d.ALUResult;
        q.writeReg  <= d.writeReg;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues word loads/stores over a req/ready handshake and fills MEM/WB.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int SIZE     = mem_access_stage_pkg::SIZE,
  parameter int REG_ADDR = mem_access_stage_pkg::REG_ADDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                MemToReg,
  input  logic                RegWrite,
  input  logic [SIZE-1:0]     ALUResult,
  input  logic [SIZE-1:0]     storeData,
  input  logic [REG_ADDR-1:0] writeReg,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [SIZE-1:0]     dmem_addr,
  output logic [SIZE-1:0]     dmem_wdata,
  input  logic                dmem_ready,
  input  logic [SIZE-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic                wb_MemToReg,
  output logic                wb_RegWrite,
  output logic [SIZE-1:0]     wb_readData,
  output logic [SIZE-1:0]     wb_ALUResult,
  output logic [REG_ADDR-1:0] wb_writeReg
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                misaligned
`endif
);

  import mem_access_stage_pkg::*;

  state_t              state, stateNext;
  logic                weQ, m2rQ, rwQ;
  logic [SIZE-1:0]     addrQ, wdataQ;
  logic [REG_ADDR-1:0] regQ;
  logic                isMem, misal, capture, wbEn;
  memWb_t              wbD, wbQ;

  always_comb begin
    isMem = MemRead | MemWrite;
`ifdef MEM_ALIGN_CHECK_EN
    misal = in_valid && isMem && (ALUResult[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    stateNext = state;
    capture   = 1'b0;
    wbEn      = 1'b0;
    wbD       = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (isMem && !misal) begin
            capture   = 1'b1;
            stateNext = BUSY;
          end else begin
            // ALU op, or a trapped misaligned access that retires without writing.
            wbEn          = 1'b1;
            wbD.valid     = 1'b1;
            wbD.MemToReg  = MemToReg;
            wbD.RegWrite  = RegWrite && !misal;
            wbD.ALUResult = ALUResult;
            wbD.writeReg  = writeReg;
          end
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          stateNext     = IDLE;
          wbEn          = 1'b1;
          wbD.valid     = 1'b1;
          wbD.MemToReg  = m2rQ;
          wbD.RegWrite  = rwQ && !weQ;
          wbD.readData  = weQ ? '0 : dmem_rdata;
          wbD.ALUResult = addrQ;
          wbD.writeReg  = regQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      weQ    <= 1'b0;
      m2rQ   <= 1'b0;
      rwQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      regQ   <= '0;
    end else begin
      state <= stateNext;
      if (capture) begin
        // Both MemRead and MemWrite set resolves to a store.
        weQ    <= MemWrite;
        m2rQ   <= MemToReg;
        rwQ    <= RegWrite;
        addrQ  <= ALUResult;
        wdataQ <= storeData;
        regQ   <= writeReg;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned <= 1'b0;
    else        misaligned <= (state == IDLE) && misal;
  end
`endif

  always_comb begin
    stall      = (state == BUSY);
    dmem_req   = (state == BUSY);
    dmem_we    = (state == BUSY) && weQ;
    dmem_addr  = addrQ;
    dmem_wdata = wdataQ;
  end

  mem_wb_reg u_memWb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (wbEn),
    .d    (wbD),
    .q    (wbQ)
  );

  always_comb begin
    wb_valid     = wbQ.valid;
    wb_MemToReg  = wbQ.MemToReg;
    wb_RegWrite  = wbQ.valid && wbQ.RegWrite;
    wb_readData  = wbQ.readData;
    wb_ALUResult = wbQ.ALUResult;
    wb_writeReg  = wbQ.writeReg;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; also covers MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic        in_valid, MemRead, MemWrite, MemToReg, RegWrite;
  logic [31:0] ALUResult, storeData;
  logic [4:0]  writeReg;
  logic        stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_MemToReg, wb_RegWrite;
  logic [31:0] wb_readData, wb_ALUResult;
  logic [4:0]  wb_writeReg;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage #(.SIZE(32), .REG_ADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUResult(ALUResult), .storeData(storeData), .writeReg(writeReg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_MemToReg(wb_MemToReg),
    .wb_RegWrite(wb_RegWrite), .wb_readData(wb_readData),
    .wb_ALUResult(wb_ALUResult), .wb_writeReg(wb_writeReg)
`ifdef MEM_ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd_idx);
    in_valid = v; MemRead = rd; MemWrite = wr; MemToReg = m2r; RegWrite = rw;
    ALUResult = addr; storeData = sd; writeReg = rd_idx;
  endtask

  initial begin
    rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #3;
    checkEq("rst_stall", {31'b0, stall}, 32'd0);
    checkEq("rst_req", {31'b0, dmem_req}, 32'd0);
    checkEq("rst_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkEq("rst_wbalu", wb_ALUResult, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // ALU op: one-cycle latency, no stall
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_002A, 32'h0, 5'd5);
    checkEq("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    checkEq("alu_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkEq("alu_wbalu", wb_ALUResult, 32'h2A);
    checkEq("alu_wbreg", {27'b0, wb_writeReg}, 32'd5);
    checkEq("alu_wbrw", {31'b0, wb_RegWrite}, 32'd1);
    checkEq("alu_wbrd", wb_readData, 32'h0);
    checkEq("alu_stall2", {31'b0, stall}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    checkEq("idle_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkEq("idle_hold_alu", wb_ALUResult, 32'h2A);

    // Load at 0x100, ready in the third BUSY cycle, then an ALU op back-to-back
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkEq("ld_stall", {31'b0, stall}, 32'd1);
      checkEq("ld_req", {31'b0, dmem_req}, 32'd1);
      checkEq("ld_we", {31'b0, dmem_we}, 32'd0);
      checkEq("ld_addr", dmem_addr, 32'h100);
      checkEq("ld_wbvalid", {31'b0, wb_valid}, 32'd0);
      if (i == 2) begin dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    dmem_ready = 1'b0; dmem_rdata = '0;
    checkEq("ld_wbvalid1", {31'b0, wb_valid}, 32'd1);
    checkEq("ld_wbm2r", {31'b0, wb_MemToReg}, 32'd1);
    checkEq("ld_wbrd", wb_readData, 32'hDEAD_BEEF);
    checkEq("ld_wbreg", {27'b0, wb_writeReg}, 32'd7);
    checkEq("ld_wbrw", {31'b0, wb_RegWrite}, 32'd1);
    checkEq("ld_stall_end", {31'b0, stall}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd9);
    tick();
    checkEq("b2b_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkEq("b2b_wbalu", wb_ALUResult, 32'h55);
    checkEq("b2b_wbrd", wb_readData, 32'h0);
    checkEq("b2b_stall", {31'b0, stall}, 32'd0);

    // Store at 0x204, ready in the first BUSY cycle; RegWrite must be suppressed
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 32'h1234, 5'd3);
    tick();
    checkEq("st_req", {31'b0, dmem_req}, 32'd1);
    checkEq("st_we", {31'b0, dmem_we}, 32'd1);
    checkEq("st_wdata", dmem_wdata, 32'h1234);
    checkEq("st_addr", dmem_addr, 32'h204);
    dmem_ready = 1'b1; dmem_rdata = 32'hAAAA_5555;
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checkEq("st_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkEq("st_wbrw", {31'b0, wb_RegWrite}, 32'd0);
    checkEq("st_wbrd", wb_readData, 32'h0);
    checkEq("st_wbalu", wb_ALUResult, 32'h204);
    checkEq("st_req_end", {31'b0, dmem_req}, 32'd0);

    // MemRead and MemWrite together behave as a store
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h77, 5'd4);
    tick();
    checkEq("rw_we", {31'b0, dmem_we}, 32'd1);
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checkEq("rw_wbrd", wb_readData, 32'h0);
    checkEq("rw_wbrw", {31'b0, wb_RegWrite}, 32'd0);

    // dmem_ready in IDLE is ignored
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checkEq("spur_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkEq("spur_req", {31'b0, dmem_req}, 32'd0);

    // Low address bits: trapped with the check enabled, passed through otherwise
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd6);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checkEq("mis_req", {31'b0, dmem_req}, 32'd0);
    checkEq("mis_flag", {31'b0, misaligned}, 32'd1);
    checkEq("mis_wbvalid", {31'b0, wb_valid}, 32'd1);
    checkEq("mis_wbrw", {31'b0, wb_RegWrite}, 32'd0);
    checkEq("mis_wbrd", wb_readData, 32'h0);
    tick();
    checkEq("mis_flag_end", {31'b0, misaligned}, 32'd0);
`else
    checkEq("una_req", {31'b0, dmem_req}, 32'd1);
    checkEq("una_addr", dmem_addr, 32'h102);
    dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checkEq("una_wbrd", wb_readData, 32'h0BAD_F00D);
`endif

    // Asynchronous reset while BUSY
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd8);
    tick();
    checkEq("rb_req_pre", {31'b0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkEq("rb_req", {31'b0, dmem_req}, 32'd0);
    checkEq("rb_stall", {31'b0, stall}, 32'd0);
    checkEq("rb_wbvalid", {31'b0, wb_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    rst_n = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_ready = 1'b0;
    checkEq("rb_post_wbvalid", {31'b0, wb_valid}, 32'd0);
    checkEq("rb_post_req", {31'b0, dmem_req}, 32'd0);
    checkEq("rb_post_stall", {31'b0, stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
